mfb_fifo_bram_pkt: RTL and testbench
====================================

Name: mfb_fifo_bram_pkt

Overview:
- Parametrised successor of the MFB BRAM FIFO: a single-clock, first-word-fall-through MFB FIFO with generalised depth and word geometry.
- Adds programmable almost-full and almost-empty flags, an occupancy counter, and an optional packet mode. In packet mode, words are released to TX only once an EOF has been stored.
- Sits between MFB producers (e.g. MAC RX) and consumers that need frame-tail buffering or back-pressure hints.

Parameters:
REGIONS, 4, number of MFB regions per word
REGION_SIZE, 8, blocks per region (power of 2)
BLOCK_SIZE, 8, items per block (power of 2)
ITEM_WIDTH, 8, bits per item
ITEMS, 1024, capacity in MFB words (power of 2, >=16)
PKT_MODE, 0, 0 = cut-through, 1 = release only up to the last stored EOF word
AFULL_OFFSET, 4, AFULL asserted when STATUS >= ITEMS-AFULL_OFFSET
AEMPTY_OFFSET, 4, AEMPTY asserted when STATUS <= AEMPTY_OFFSET
DEVICE, "7SERIES", memory primitive selection ("7SERIES", "ULTRASCALE", "AGILEX")

Ports:
CLK  in  1  clock
RESET  in  1  synchronous reset, active-high
RX_DATA  in  REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH  word data
RX_SOF_POS  in  REGIONS*max(1,log2(REGION_SIZE))  SOF block index per region
RX_EOF_POS  in  REGIONS*max(1,log2(REGION_SIZE*BLOCK_SIZE))  EOF item index per region
RX_SOF  in  REGIONS  SOF valid per region
RX_EOF  in  REGIONS  EOF valid per region
RX_SRC_RDY  in  1  word valid
RX_DST_RDY  out  1  FIFO accepts word
TX_DATA, TX_SOF_POS, TX_EOF_POS, TX_SOF, TX_EOF  out  same widths as RX  output word
TX_SRC_RDY  out  1  output word valid
TX_DST_RDY  in  1  consumer accepts word
STATUS  out  log2(ITEMS)+1  stored words, including the output register
AFULL  out  1  almost full
AEMPTY  out  1  almost empty

Behaviour:
- Clock and reset: single clock CLK. RESET is synchronous and active-high.
- Reset state: all pointers and the counter are 0. Reset values are TX_SRC_RDY=0, RX_DST_RDY=0, STATUS=0, AFULL=0, AEMPTY=1. RX_DST_RDY rises the first cycle after RESET deasserts.
- Reset mid-operation: all stored words are lost. No TX word is presented in the reset cycle.
- Transfers:
  - Write = RX_SRC_RDY & RX_DST_RDY.
  - Read = TX_SRC_RDY & TX_DST_RDY.
  - RX_DST_RDY = (STATUS < ITEMS); it is independent of RX_SRC_RDY.
  - TX side: TX_SRC_RDY is held with TX_* stable until accepted.
- Word storage: the whole word is stored with SOF/EOF metadata unmodified. Ordering is strict FIFO.
- Storage structure: circular memory with write pointer WP, read pointer RP and commit pointer CP, plus a one-word output register (FWFT). Pointers wrap modulo ITEMS.
- Latency: a word written in cycle t into an empty FIFO appears with TX_SRC_RDY=1 at cycle t+2 (one cycle memory read plus output register). A word may not reach TX in the same cycle it is written.
- Throughput: with TX_DST_RDY=1 continuously, one word per cycle is sustained in both modes once the pipeline is primed.
- STATUS arithmetic:
  - STATUS +1 on write only, -1 on read only, unchanged on simultaneous write and read.
  - STATUS = ITEMS is full. A simultaneous read when full frees space; RX_DST_RDY rises the next cycle.
- Flags: AFULL and AEMPTY are registered and derived from the next-cycle STATUS, so they are cycle-aligned with STATUS.
- PKT_MODE=0: CP tracks WP; every stored word is eligible.
- PKT_MODE=1 commit rule:
  - When a written word has any RX_EOF bit set, CP := WP+1 in the following cycle.
  - Only words before CP may enter the output register.
  - A word containing EOF of frame A and SOF of frame B is released as a whole, so the head of B may leave before B's EOF.
- PKT_MODE=1 deadlock avoidance:
  - If STATUS = ITEMS and CP = RP (no eligible word), set CP := WP (force release).
  - Normal EOF gating resumes for subsequent words.
- Empty and read conditions: TX_SRC_RDY=0 whenever the output register holds no valid word. A read of an empty FIFO cannot occur.

Test Plan:
- Reset, then single word (RX_SOF=0001, RX_EOF=0001) at cycle t -> TX_SRC_RDY=1 at t+2 with identical data and metadata; STATUS sequence 0,1,...,0.
- Continuous 10000-word random MFB frame stream (60–512 B), random RX_SRC_RDY/TX_DST_RDY, both PKT_MODE values -> scoreboard exact frame match, no loss or reorder.
- ITEMS=16, TX_DST_RDY=0, 20 write attempts -> exactly 16 accepted; RX_DST_RDY=0 at STATUS=16; AFULL set at STATUS=12; AEMPTY clear at STATUS=5.
- PKT_MODE=1, write 3 words without EOF -> TX_SRC_RDY stays 0. Write a 4th word with EOF -> TX_SRC_RDY=1 two cycles later, and all 4 words drain back-to-back.
- PKT_MODE=1, ITEMS=16, 20-word frame with TX_DST_RDY=1 -> forced release at STATUS=16; all 20 words delivered in order.
- RESET asserted for 1 cycle while STATUS=7 -> next cycle STATUS=0, TX_SRC_RDY=0, AEMPTY=1; the following cycle RX_DST_RDY=1.

Source files
------------

// File: rtl/mfb_fifo_bram_pkt.sv
// Single-clock first-word-fall-through MFB FIFO on inferred block RAM with occupancy
// flags and an optional packet mode that releases words only up to the last stored EOF.
module mfb_fifo_bram_pkt #(
   parameter int    REGIONS       = 4,
   parameter int    REGION_SIZE   = 8,
   parameter int    BLOCK_SIZE    = 8,
   parameter int    ITEM_WIDTH    = 8,
   parameter int    ITEMS         = 1024,
   parameter int    PKT_MODE      = 0,
   parameter int    AFULL_OFFSET  = 4,
   parameter int    AEMPTY_OFFSET = 4,
   parameter string DEVICE        = "7SERIES",
   localparam int   DATA_W = REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH,
   localparam int   SOFP_W = REGIONS*((REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1),
   localparam int   EOFP_W = REGIONS*((REGION_SIZE*BLOCK_SIZE > 1) ? $clog2(REGION_SIZE*BLOCK_SIZE) : 1),
   localparam int   ST_W   = $clog2(ITEMS)+1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] RX_DATA,
   input  logic [SOFP_W-1:0] RX_SOF_POS,
   input  logic [EOFP_W-1:0] RX_EOF_POS,
   input  logic [REGIONS-1:0] RX_SOF,
   input  logic [REGIONS-1:0] RX_EOF,
   input  logic              RX_SRC_RDY,
   output logic              RX_DST_RDY,
   output logic [DATA_W-1:0] TX_DATA,
   output logic [SOFP_W-1:0] TX_SOF_POS,
   output logic [EOFP_W-1:0] TX_EOF_POS,
   output logic [REGIONS-1:0] TX_SOF,
   output logic [REGIONS-1:0] TX_EOF,
   output logic              TX_SRC_RDY,
   input  logic              TX_DST_RDY,
   output logic [ST_W-1:0]   STATUS,
   output logic              AFULL,
   output logic              AEMPTY
);

   localparam int AW     = $clog2(ITEMS);
   localparam int WORD_W = DATA_W + SOFP_W + EOFP_W + 2*REGIONS;
   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0] ITEMS_V   = (AW+1)'(ITEMS);
   localparam logic [AW:0] AFULL_TH  = (AW+1)'(ITEMS - AFULL_OFFSET);
   localparam logic [AW:0] AEMPTY_TH = (AW+1)'(AEMPTY_OFFSET);

   // Pointers carry one extra bit so a completely full memory differs from an empty one.
   logic [AW:0] wp_q, wp_d, rp_q, rp_d, cp_q, cp_d;
   logic [AW:0] status_q, status_d;
   logic        out_vld_q, out_vld_d;
   logic        rx_rdy_q, afull_q, aempty_q;
   logic        wr_en, rd_en, load_en;
   logic [AW:0] elig_ptr;
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word_q;

   assign RX_DST_RDY = rx_rdy_q & ~RESET;
   assign TX_SRC_RDY = out_vld_q & ~RESET;
   assign wr_en      = RX_SRC_RDY & RX_DST_RDY;
   assign rd_en      = TX_SRC_RDY & TX_DST_RDY;
   assign elig_ptr   = (PKT_MODE != 0) ? cp_q : wp_q;
   // The output register refills whenever it is empty or being drained this cycle.
   assign load_en    = (elig_ptr != rp_q) & (~out_vld_q | rd_en) & ~RESET;

   assign wr_word = {RX_DATA, RX_SOF_POS, RX_EOF_POS, RX_SOF, RX_EOF};
   assign {TX_DATA, TX_SOF_POS, TX_EOF_POS, TX_SOF, TX_EOF} = rd_word_q;

   assign STATUS = status_q;
   assign AFULL  = afull_q;
   assign AEMPTY = aempty_q;

   always_comb begin
      wp_d      = wp_q;
      rp_d      = rp_q;
      cp_d      = cp_q;
      status_d  = status_q;
      out_vld_d = out_vld_q;
      if (wr_en)
         wp_d = wp_q + PTR_ONE;
      if (load_en)
         rp_d = rp_q + PTR_ONE;
      if (wr_en && !rd_en)
         status_d = status_q + PTR_ONE;
      else if (!wr_en && rd_en)
         status_d = status_q - PTR_ONE;
      if (load_en)
         out_vld_d = 1'b1;
      else if (rd_en)
         out_vld_d = 1'b0;
      // A full FIFO with nothing committed can never see an EOF, so release everything.
      if (PKT_MODE == 0)
         cp_d = wp_d;
      else if (status_q == ITEMS_V && cp_q == rp_q)
         cp_d = wp_q;
      else if (wr_en && (|RX_EOF))
         cp_d = wp_q + PTR_ONE;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wp_q      <= '0;
         rp_q      <= '0;
         cp_q      <= '0;
         status_q  <= '0;
         out_vld_q <= 1'b0;
         rx_rdy_q  <= 1'b0;
         afull_q   <= 1'b0;
         aempty_q  <= 1'b1;
      end else begin
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         cp_q      <= cp_d;
         status_q  <= status_d;
         out_vld_q <= out_vld_d;
         rx_rdy_q  <= (status_d < ITEMS_V);
         afull_q   <= (status_d >= AFULL_TH);
         aempty_q  <= (status_d <= AEMPTY_TH);
      end
   end

   // The RAM's registered read port doubles as the FWFT output register.
   generate
      if (DEVICE == "AGILEX") begin : g_m20k
         (* ramstyle = "M20K" *) logic [WORD_W-1:0] mem [ITEMS];
         always_ff @(posedge CLK) begin
            if (wr_en)
               mem[wp_q[AW-1:0]] <= wr_word;
            if (load_en)
               rd_word_q <= mem[rp_q[AW-1:0]];
         end
      end else begin : g_bram
         (* ram_style = "block" *) logic [WORD_W-1:0] mem [ITEMS];
         always_ff @(posedge CLK) begin
            if (wr_en)
               mem[wp_q[AW-1:0]] <= wr_word;
            if (load_en)
               rd_word_q <= mem[rp_q[AW-1:0]];
         end
      end
   endgenerate

endmodule

// File: tb/tb_mfb_fifo_bram_pkt.sv
// Bench for mfb_fifo_bram_pkt: one cut-through and one packet-mode instance (ITEMS=16),
// control-flag table, hand-timed corner sequences and a random stream against a count model.
module tb_mfb_fifo_bram_pkt;

   localparam int REG   = 4;
   localparam int RSZ   = 8;
   localparam int BSZ   = 8;
   localparam int IW    = 8;
   localparam int ITEMS = 16;
   localparam int DW    = REG*RSZ*BSZ*IW;
   localparam int SW    = REG*3;
   localparam int EW    = REG*6;

   typedef struct packed {
      logic [DW-1:0]  data;
      logic [SW-1:0]  sofp;
      logic [EW-1:0]  eofp;
      logic [REG-1:0] sof;
      logic [REG-1:0] eof;
   } word_t;

   typedef struct packed {
      logic       src;
      logic       dst;
      logic [4:0] st;
      logic       rdy;
      logic       af;
      logic       ae;
      logic       txv;
   } row_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst     [2];
   logic [DW-1:0]  rx_data [2];
   logic [SW-1:0]  rx_sofp [2];
   logic [EW-1:0]  rx_eofp [2];
   logic [REG-1:0] rx_sof  [2];
   logic [REG-1:0] rx_eof  [2];
   logic           rx_vld  [2];
   logic           rx_rdy  [2];
   logic [DW-1:0]  tx_data [2];
   logic [SW-1:0]  tx_sofp [2];
   logic [EW-1:0]  tx_eofp [2];
   logic [REG-1:0] tx_sof  [2];
   logic [REG-1:0] tx_eof  [2];
   logic           tx_vld  [2];
   logic           tx_dst  [2];
   logic [4:0]     status  [2];
   logic           afull   [2];
   logic           aempty  [2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         mfb_fifo_bram_pkt #(
            .REGIONS(REG), .REGION_SIZE(RSZ), .BLOCK_SIZE(BSZ), .ITEM_WIDTH(IW),
            .ITEMS(ITEMS), .PKT_MODE(gi), .AFULL_OFFSET(4), .AEMPTY_OFFSET(4),
            .DEVICE("7SERIES")
         ) dut (
            .CLK(clk), .RESET(rst[gi]),
            .RX_DATA(rx_data[gi]), .RX_SOF_POS(rx_sofp[gi]), .RX_EOF_POS(rx_eofp[gi]),
            .RX_SOF(rx_sof[gi]), .RX_EOF(rx_eof[gi]), .RX_SRC_RDY(rx_vld[gi]), .RX_DST_RDY(rx_rdy[gi]),
            .TX_DATA(tx_data[gi]), .TX_SOF_POS(tx_sofp[gi]), .TX_EOF_POS(tx_eofp[gi]),
            .TX_SOF(tx_sof[gi]), .TX_EOF(tx_eof[gi]), .TX_SRC_RDY(tx_vld[gi]), .TX_DST_RDY(tx_dst[gi]),
            .STATUS(status[gi]), .AFULL(afull[gi]), .AEMPTY(aempty[gi])
         );
      end
   endgenerate

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_word(input string name, input word_t act, input word_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got data[31:0]=%h sof=%h eof=%h expected data[31:0]=%h sof=%h eof=%h (t=%0t)",
                  name, act.data[31:0], act.sof, act.eof, exp.data[31:0], exp.sof, exp.eof, $time);
      end
   endtask

   function automatic word_t rand_word(input int eof_pct);
      word_t w;
      for (int i = 0; i < DW/32; i++) w.data[i*32 +: 32] = $urandom;
      w.sofp = SW'($urandom);
      w.eofp = EW'($urandom);
      w.sof  = REG'($urandom);
      w.eof  = (int'($urandom_range(99)) < eof_pct) ? REG'($urandom_range(15, 1)) : '0;
      return w;
   endfunction

   function automatic word_t tx_word(input int m);
      return {tx_data[m], tx_sofp[m], tx_eofp[m], tx_sof[m], tx_eof[m]};
   endfunction

   function automatic row_t mkrow(input logic s, input logic d, input int st, input logic r,
                                  input logic af, input logic ae, input logic v);
      row_t x;
      x.src = s; x.dst = d; x.st = 5'(st); x.rdy = r; x.af = af; x.ae = ae; x.txv = v;
      return x;
   endfunction

   // Advance to the next cycle, drive inputs, settle; outputs then reflect this cycle.
   task automatic step(input int m, input logic r, input logic src, input logic dst, input word_t w);
      @(negedge clk);
      rst[m]     = r;
      rx_vld[m]  = src;
      tx_dst[m]  = dst;
      rx_data[m] = w.data;
      rx_sofp[m] = w.sofp;
      rx_eofp[m] = w.eofp;
      rx_sof[m]  = w.sof;
      rx_eof[m]  = w.eof;
      #1;
   endtask

   // Stream checked against a count-based model: a word is eligible one cycle after it is
   // stored (cut-through) or committed (packet mode), and appears on TX one cycle later.
   task automatic run_stream(input int m, input int nwords, input bit rnd);
      word_t q[$];
      word_t cur;
      int wr = 0, rd = 0, commit = 0, prev_elig = 0, cyc = 0, max_st = 0, st, elig, phase, pct;
      bit first = 1'b1;
      bit src, dst, exp_v, exp_rdy, we, re;
      step(m, 1'b1, 1'b0, 1'b0, '0);
      cur = rand_word(rnd ? 30 : 0);
      if (nwords == 1) cur.eof = 4'b1000;
      while (rd < nwords && cyc < 40000) begin
         cyc++;
         phase = (cyc / 300) % 3;
         if (rnd) begin
            src = (wr < nwords) && ($urandom_range(3) != 0);
            dst = (phase == 0) ? ($urandom_range(9) != 0) :
                  (phase == 1) ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
         end else begin
            src = (wr < nwords);
            dst = 1'b1;
         end
         step(m, 1'b0, src, dst, cur);
         st      = wr - rd;
         exp_v   = (prev_elig > rd);
         exp_rdy = !first && (st < ITEMS);
         chk("tx_src_rdy", tx_vld[m], exp_v);
         chk("status", status[m], st);
         chk("rx_dst_rdy", rx_rdy[m], exp_rdy);
         chk("afull", afull[m], st >= ITEMS - 4);
         chk("aempty", aempty[m], st <= 4);
         if (exp_v && tx_vld[m]) chk_word("tx_word", tx_word(m), q[0]);
         if (int'(status[m]) > max_st) max_st = int'(status[m]);
         we   = src && exp_rdy;
         re   = exp_v && dst;
         elig = (m == 1) ? commit : wr;
         if (m == 1) begin
            if (st == ITEMS && commit == rd + int'(exp_v)) commit = wr;
            else if (we && cur.eof != '0) commit = wr + 1;
         end
         prev_elig = elig;
         if (we) begin
            q.push_back(cur);
            wr++;
            pct = !rnd ? 0 : ((phase == 2) ? 3 : 30);
            cur = rand_word(pct);
            if (wr == nwords - 1) cur.eof = 4'b1000;
         end
         if (re) begin
            q.delete(0);
            rd++;
         end
         first = 1'b0;
      end
      chk("words_delivered", rd, nwords);
      if (!rnd) chk("peak_status", max_st, ITEMS);
      step(m, 1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      row_t  tbl [24];
      word_t wa, wd;
      word_t wb [4];

      tbl[0]  = mkrow(1, 0,  0, 0, 0, 1, 0);
      tbl[1]  = mkrow(1, 0,  0, 1, 0, 1, 0);
      tbl[2]  = mkrow(1, 0,  1, 1, 0, 1, 0);
      tbl[3]  = mkrow(1, 0,  2, 1, 0, 1, 1);
      tbl[4]  = mkrow(1, 0,  3, 1, 0, 1, 1);
      tbl[5]  = mkrow(1, 0,  4, 1, 0, 1, 1);
      tbl[6]  = mkrow(1, 0,  5, 1, 0, 0, 1);
      tbl[7]  = mkrow(1, 0,  6, 1, 0, 0, 1);
      tbl[8]  = mkrow(1, 0,  7, 1, 0, 0, 1);
      tbl[9]  = mkrow(1, 0,  8, 1, 0, 0, 1);
      tbl[10] = mkrow(1, 0,  9, 1, 0, 0, 1);
      tbl[11] = mkrow(1, 0, 10, 1, 0, 0, 1);
      tbl[12] = mkrow(1, 0, 11, 1, 0, 0, 1);
      tbl[13] = mkrow(1, 0, 12, 1, 1, 0, 1);
      tbl[14] = mkrow(1, 0, 13, 1, 1, 0, 1);
      tbl[15] = mkrow(1, 0, 14, 1, 1, 0, 1);
      tbl[16] = mkrow(1, 0, 15, 1, 1, 0, 1);
      tbl[17] = mkrow(1, 0, 16, 0, 1, 0, 1);
      tbl[18] = mkrow(1, 0, 16, 0, 1, 0, 1);
      tbl[19] = mkrow(1, 0, 16, 0, 1, 0, 1);
      tbl[20] = mkrow(0, 1, 16, 0, 1, 0, 1);
      tbl[21] = mkrow(1, 1, 15, 1, 1, 0, 1);
      tbl[22] = mkrow(0, 1, 15, 1, 1, 0, 1);
      tbl[23] = mkrow(0, 0, 14, 1, 1, 0, 1);

      for (int m = 0; m < 2; m++) begin
         rst[m] = 1'b1; rx_vld[m] = 1'b0; tx_dst[m] = 1'b0;
         rx_data[m] = '0; rx_sofp[m] = '0; rx_eofp[m] = '0; rx_sof[m] = '0; rx_eof[m] = '0;
      end

      // Reset state, then RX_DST_RDY rising one cycle after reset is released.
      @(negedge clk);
      @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("rst_status", status[m], 0);
         chk("rst_tx_src_rdy", tx_vld[m], 0);
         chk("rst_rx_dst_rdy", rx_rdy[m], 0);
         chk("rst_afull", afull[m], 0);
         chk("rst_aempty", aempty[m], 1);
      end
      @(negedge clk);
      #1;
      for (int m = 0; m < 2; m++) chk("rdy_after_rst", rx_rdy[m], 1);

      // Single word: written at t, visible at t+2 unchanged.
      step(0, 1'b1, 1'b0, 1'b0, '0);
      step(0, 1'b0, 1'b0, 1'b0, '0);
      wa = rand_word(0);
      wa.sof = 4'b0001; wa.eof = 4'b0001;
      step(0, 1'b0, 1'b1, 1'b0, wa);
      chk("single_rdy", rx_rdy[0], 1);
      chk("single_t0_tx", tx_vld[0], 0);
      step(0, 1'b0, 1'b0, 1'b0, '0);
      chk("single_t1_tx", tx_vld[0], 0);
      chk("single_t1_status", status[0], 1);
      step(0, 1'b0, 1'b0, 1'b1, '0);
      chk("single_t2_tx", tx_vld[0], 1);
      chk_word("single_t2_word", tx_word(0), wa);
      step(0, 1'b0, 1'b0, 1'b0, '0);
      chk("single_t3_tx", tx_vld[0], 0);
      chk("single_t3_status", status[0], 0);

      // Fill to full with TX stalled, then read-while-full and simultaneous read/write.
      step(0, 1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 24; k++) begin
         step(0, 1'b0, tbl[k].src, tbl[k].dst, rand_word(0));
         chk("tbl_status", status[0], tbl[k].st);
         chk("tbl_rx_dst_rdy", rx_rdy[0], tbl[k].rdy);
         chk("tbl_afull", afull[0], tbl[k].af);
         chk("tbl_aempty", aempty[0], tbl[k].ae);
         chk("tbl_tx_src_rdy", tx_vld[0], tbl[k].txv);
      end

      // Reset while STATUS=7.
      step(0, 1'b1, 1'b0, 1'b0, '0);
      step(0, 1'b0, 1'b0, 1'b0, '0);
      for (int k = 0; k < 7; k++) step(0, 1'b0, 1'b1, 1'b0, rand_word(0));
      wd = rand_word(0);
      step(0, 1'b1, 1'b1, 1'b0, wd);
      chk("midrst_status_before", status[0], 7);
      chk("midrst_tx_in_reset", tx_vld[0], 0);
      step(0, 1'b0, 1'b0, 1'b0, '0);
      chk("midrst_status", status[0], 0);
      chk("midrst_tx", tx_vld[0], 0);
      chk("midrst_aempty", aempty[0], 1);
      chk("midrst_afull", afull[0], 0);
      chk("midrst_rdy_low", rx_rdy[0], 0);
      step(0, 1'b0, 1'b0, 1'b0, '0);
      chk("midrst_rdy_high", rx_rdy[0], 1);
      chk("midrst_status2", status[0], 0);

      // Packet mode: no release before EOF, then four words back-to-back.
      step(1, 1'b1, 1'b0, 1'b0, '0);
      step(1, 1'b0, 1'b0, 1'b0, '0);
      for (int k = 0; k < 4; k++) wb[k] = rand_word(0);
      wb[3].eof = 4'b0001;
      for (int k = 0; k < 3; k++) step(1, 1'b0, 1'b1, 1'b0, wb[k]);
      for (int k = 0; k < 3; k++) begin
         step(1, 1'b0, 1'b0, 1'b0, '0);
         chk("pkt_hold_tx", tx_vld[1], 0);
         chk("pkt_hold_status", status[1], 3);
      end
      step(1, 1'b0, 1'b1, 1'b0, wb[3]);
      chk("pkt_eof_t0_tx", tx_vld[1], 0);
      step(1, 1'b0, 1'b0, 1'b1, '0);
      chk("pkt_eof_t1_tx", tx_vld[1], 0);
      chk("pkt_eof_t1_status", status[1], 4);
      for (int k = 0; k < 4; k++) begin
         step(1, 1'b0, 1'b0, 1'b1, '0);
         chk("pkt_drain_tx", tx_vld[1], 1);
         chk_word("pkt_drain_word", tx_word(1), wb[k]);
      end
      step(1, 1'b0, 1'b0, 1'b0, '0);
      chk("pkt_drained_tx", tx_vld[1], 0);
      chk("pkt_drained_status", status[1], 0);

      // Packet mode: 20-word frame longer than the FIFO needs the forced release.
      run_stream(1, 20, 1'b0);
      // Random streams, 5000 words per mode.
      run_stream(0, 5000, 1'b1);
      run_stream(1, 5000, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
